// File: rtl/xor_gate.sv
// Bit-serial XOR cipher stage: combinational a^b plus an accept-driven word assembler
// with group/word completion pulses. Optional parity output under XOR_GATE_PARITY_EN.
module xor_gate #(
  parameter int WORD_BITS  = 64,
  parameter int GROUP_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a,
  input  logic                         b,
  input  logic                         in_valid,
  input  logic                         clear,
  output logic                         out,
  output logic                         out_q,
  output logic [WORD_BITS-1:0]         word_q,
  output logic [$clog2(WORD_BITS)-1:0] bit_cnt,
  output logic                         group_done,
`ifdef XOR_GATE_PARITY_EN
  output logic                         parity_q,
`endif
  output logic                         word_done
);

  localparam int CNT_W = $clog2(WORD_BITS);
  localparam int GRP_W = (GROUP_BITS > 1) ? $clog2(GROUP_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WORD_BITS - 1);
  localparam logic [GRP_W-1:0] GRP_RELOAD = GRP_W'(GROUP_BITS - 1);

  // Bits remaining in the current group; terminal count marks the group's final bit.
  // Words are whole multiples of groups, so this stays aligned across word wrap.
  logic [GRP_W-1:0] grp_left;
  logic             grp_tc;
  logic             word_last;
  logic             bit_x;

  assign bit_x     = a ^ b;
  assign out       = bit_x;
  assign grp_tc    = (grp_left == '0);
  assign word_last = (bit_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= 1'b0;
      word_q     <= '0;
      bit_cnt    <= '0;
      grp_left   <= GRP_RELOAD;
      group_done <= 1'b0;
      word_done  <= 1'b0;
    end else if (clear) begin
      out_q      <= 1'b0;
      word_q     <= '0;
      bit_cnt    <= '0;
      grp_left   <= GRP_RELOAD;
      group_done <= 1'b0;
      word_done  <= 1'b0;
    end else if (in_valid) begin
      out_q      <= bit_x;
      word_q     <= {word_q[WORD_BITS-2:0], bit_x};
      bit_cnt    <= word_last ? '0 : bit_cnt + CNT_W'(1);
      grp_left   <= grp_tc ? GRP_RELOAD : grp_left - GRP_W'(1);
      group_done <= grp_tc;
      word_done  <= word_last;
    end else begin
      group_done <= 1'b0;
      word_done  <= 1'b0;
    end
  end

`ifdef XOR_GATE_PARITY_EN
  // Running parity restarts on the first bit of each word and holds between accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (clear) begin
      parity_q <= 1'b0;
    end else if (in_valid) begin
      parity_q <= ((bit_cnt == '0) ? 1'b0 : parity_q) ^ bit_x;
    end
  end
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Directed self-checking bench for xor_gate: truth table, encrypt/decrypt words,
// idle gaps, async reset mid-word, clear priority, and parity when enabled.
module tb_xor_gate;

  localparam logic [63:0] PT  = 64'h7472616261_6C686F;
  localparam logic [63:0] KEY = 64'h63696E6363696E63;
  localparam logic [63:0] CT  = 64'h171B0F010205060C;

  logic        clk = 1'b0;
  logic        rst, a, b, in_valid, clear;
  logic        out, out_q, group_done, word_done;
  logic [63:0] word_q;
  logic [5:0]  bit_cnt;
`ifdef XOR_GATE_PARITY_EN
  logic        parity_q;
`endif

  int errors = 0;
  int checks = 0;
  int gcnt, wcnt;

  always #5 clk = ~clk;

  xor_gate #(.WORD_BITS(64), .GROUP_BITS(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .clear(clear),
    .out(out), .out_q(out_q), .word_q(word_q), .bit_cnt(bit_cnt),
    .group_done(group_done),
`ifdef XOR_GATE_PARITY_EN
    .parity_q(parity_q),
`endif
    .word_done(word_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one pair, clock it in, sample 1ns after the edge and tally pulses.
  task automatic step(input logic va, input logic vb, input logic v);
    a = va; b = vb; in_valid = v;
    @(posedge clk); #1;
    gcnt += int'(group_done);
    wcnt += int'(word_done);
  endtask

  initial begin
    logic [63:0] tt_exp;
    rst = 1'b1; a = 1'b0; b = 1'b0; in_valid = 1'b0; clear = 1'b0;
    gcnt = 0; wcnt = 0;
    #1;
    check("reset_word_q", word_q, 64'h0);
    check("reset_bit_cnt", 64'(bit_cnt), 64'h0);
    check("reset_pulses", {62'h0, group_done, word_done}, 64'h0);
    check("reset_out_q", 64'(out_q), 64'h0);

    // Truth table while held in reset: out must remain combinational.
    tt_exp = 64'h6;
    for (int i = 0; i < 4; i++) begin
      a = i[1]; b = i[0]; #1;
      check("tt_in_reset", 64'(out), 64'(tt_exp[i]));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Truth table with in_valid=0: nothing captured.
    for (int i = 0; i < 4; i++) begin
      a = i[1]; b = i[0]; #1;
      check("tt_out", 64'(out), 64'(tt_exp[i]));
      @(posedge clk); #1;
      check("tt_word_q_idle", word_q, 64'h0);
    end
    check("tt_bit_cnt_idle", 64'(bit_cnt), 64'h0);

    // Encrypt one word MSB-first.
    gcnt = 0; wcnt = 0;
    for (int i = 63; i >= 0; i--) begin
      step(PT[i], KEY[i], 1'b1);
      if (i == 56) check("first_group_done", 64'(group_done), 64'h1);
      if (i == 55) check("group_done_one_cycle", 64'(group_done), 64'h0);
      if (i == 0)  check("word_done_on_last", 64'(word_done), 64'h1);
    end
    in_valid = 1'b0;
    check("enc_word_q", word_q, CT);
    check("enc_bit_cnt_wrap", 64'(bit_cnt), 64'h0);
    check("enc_group_pulses", 64'(gcnt), 64'd8);
    check("enc_word_pulses", 64'(wcnt), 64'd1);
    check("enc_out_q", 64'(out_q), 64'(CT[0]));
`ifdef XOR_GATE_PARITY_EN
    check("enc_parity", 64'(parity_q), 64'(^CT));
`endif
    step(1'b0, 1'b0, 1'b0);
    check("idle_pulses_clear", {62'h0, group_done, word_done}, 64'h0);
    check("idle_word_hold", word_q, CT);
`ifdef XOR_GATE_PARITY_EN
    check("idle_parity_hold", 64'(parity_q), 64'(^CT));
`endif

    // Decrypt: shifts over the previous word.
    gcnt = 0; wcnt = 0;
    for (int i = 63; i >= 0; i--) step(CT[i], KEY[i], 1'b1);
    in_valid = 1'b0;
    check("dec_word_q", word_q, PT);
    check("dec_word_pulses", 64'(wcnt), 64'd1);

    // Encrypt again with a 3-cycle gap after bit index 5 of the stream.
    gcnt = 0; wcnt = 0;
    for (int k = 0; k < 64; k++) begin
      step(PT[63-k], KEY[63-k], 1'b1);
      if (k == 5) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b1, 1'b0, 1'b0);
          check("gap_bit_cnt_hold", 64'(bit_cnt), 64'd6);
          check("gap_no_pulse", {62'h0, group_done, word_done}, 64'h0);
          check("gap_out_q_hold", 64'(out_q), 64'(CT[58]));
        end
      end
    end
    in_valid = 1'b0;
    check("gap_word_q", word_q, CT);
    check("gap_group_pulses", 64'(gcnt), 64'd8);
    check("gap_word_pulses", 64'(wcnt), 64'd1);

`ifdef XOR_GATE_PARITY_EN
    for (int k = 0; k < 63; k++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("parity_single_one", 64'(parity_q), 64'h1);
    check("parity_word_q", word_q, 64'h1);
`endif

    // Async reset after 20 accepts of ones.
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("pre_rst_bit_cnt", 64'(bit_cnt), 64'd20);
    rst = 1'b1; #1;
    check("rst_async_word_q", word_q, 64'h0);
    check("rst_async_bit_cnt", 64'(bit_cnt), 64'h0);
    check("rst_async_out_q", 64'(out_q), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("post_rst_bit_cnt", 64'(bit_cnt), 64'd1);
    check("post_rst_word_q", word_q, 64'h1);

    // Clear with in_valid high: clear wins.
    step(1'b1, 1'b0, 1'b1);
    clear = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    clear = 1'b0; in_valid = 1'b0;
    check("clear_word_q", word_q, 64'h0);
    check("clear_bit_cnt", 64'(bit_cnt), 64'h0);
    check("clear_out_q", 64'(out_q), 64'h0);
`ifdef XOR_GATE_PARITY_EN
    check("clear_parity", 64'(parity_q), 64'h0);
`endif
    step(1'b1, 1'b1, 1'b1);
    in_valid = 1'b0;
    check("after_clear_bit_cnt", 64'(bit_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
